config_chain_loader: RTL and testbench

- Transmitter end of the fabric configuration shift chain.
- Accepts bitstream words over a valid/ready stream and serialises them onto the chain's shift input, qualifying each bit with a clock-enable pulse.
- After the last bit it pulses the chain's set/latch strobe.
- Sits between the bitstream source (bus/DMA bridge) and the first tile's shift_in; cfg_shift, cfg_cen and cfg_set fan out to the chain's shift_in, cen and set_in.

---
 rtl/cfg_chain_pkg.sv | 8 +
 rtl/cfg_readback_collector.sv | 40 ++++
 rtl/config_chain_loader.sv | 100 ++++++++++
 tb/tb_config_chain_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cfg_chain_pkg.sv
// cfg_chain_pkg: shared state encoding, word width and counter sizing for the config chain loader
package cfg_chain_pkg;
  localparam int CFG_WORD_W = 32;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, SET, DONE} cfg_load_state_t;
  function automatic int cfg_len_w(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction
endpackage

// File: rtl/cfg_readback_collector.sv
// cfg_readback_collector: deserialises the chain tail into LSB-first words, flushing a partial word on the last bit
module cfg_readback_collector
  import cfg_chain_pkg::*;
#(
  parameter int WORD_W = CFG_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  input  logic              last,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);
  localparam int CW = $clog2(WORD_W);
  logic [WORD_W-1:0] col, nxt;
  logic [CW-1:0] cnt;
  always_comb nxt = col | (WORD_W'(din) << cnt);
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      cnt <= '0;
      rb_data <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (en) begin
        if (last || cnt == CW'(WORD_W - 1)) begin
          rb_data <= nxt;
          rb_valid <= 1'b1;
          col <= '0;
          cnt <= '0;
        end else begin
          col <= nxt;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: serialises bitstream words onto the config shift chain, then strobes set
// Optional readback of the chain tail is enabled with CFG_READBACK_EN.
module config_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int WORD_W   = CFG_WORD_W,
  parameter int MAX_BITS = 65536,
  parameter int LEN_W    = cfg_len_w(MAX_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_shift,
  output logic              cfg_cen,
  output logic              cfg_set,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              shift_ret
);
  cfg_load_state_t state;
  logic [WORD_W-1:0] shreg;
  logic [LEN_W-1:0] bits_left, word_bits, fill;
  always_comb fill = bits_left < LEN_W'(WORD_W) ? bits_left : LEN_W'(WORD_W);
  assign cfg_shift = cfg_cen & shreg[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bits_left <= '0;
      word_bits <= '0;
      word_ready <= 1'b0;
      cfg_cen <= 1'b0;
      cfg_set <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bits_left <= cfg_len;
          busy <= 1'b1;
          state <= cfg_len != '0 ? FETCH : SET;
          word_ready <= cfg_len != '0;
          cfg_set <= cfg_len == '0;
        end
        FETCH: if (word_valid) begin
          shreg <= word_data;
          word_bits <= fill;
          word_ready <= 1'b0;
          cfg_cen <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          word_bits <= word_bits - 1'b1;
          bits_left <= bits_left - 1'b1;
          // bits_left never drops below word_bits, so the word ends no later than the load
          if (word_bits == LEN_W'(1)) begin
            cfg_cen <= 1'b0;
            state <= bits_left == LEN_W'(1) ? SET : FETCH;
            word_ready <= bits_left != LEN_W'(1);
            cfg_set <= bits_left == LEN_W'(1);
          end
        end
        SET: begin
          cfg_set <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CFG_READBACK_EN
  cfg_readback_collector #(.WORD_W(WORD_W)) u_rb (
    .clk(clk),
    .rst(rst),
    .en(cfg_cen),
    .din(shift_ret),
    .last(cfg_cen && bits_left == LEN_W'(1)),
    .rb_data(rb_data),
    .rb_valid(rb_valid)
  );
`else
  logic unused_ret;
  assign unused_ret = shift_ret;
  assign rb_data = '0;
  assign rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: directed checks of serialisation order, timing, stalls, disturbance and readback
module tb_config_chain_loader;
  localparam int LEN_W = 17;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, word_valid = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [31:0] word_data = '0;
  logic word_ready, cfg_shift, cfg_cen, cfg_set, busy, done, rb_valid, shift_ret;
  logic [31:0] rb_data;
  logic [63:0] chain = 64'hDEAD_BEEF_0123_4567;
  int checks = 0, errors = 0, cyc = 0;
  int n_set, n_done, set_cyc, done_cyc, cen_first, bad_shift, st_cyc;
  logic bits[$];
  logic [31:0] rb_q[$];

  config_chain_loader dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .cfg_shift(cfg_shift), .cfg_cen(cfg_cen), .cfg_set(cfg_set),
    .busy(busy), .done(done), .rb_data(rb_data), .rb_valid(rb_valid),
    .shift_ret(shift_ret)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign shift_ret = chain[0];
  always @(posedge clk) if (cfg_cen) chain <= {cfg_shift, chain[63:1]};

  always @(negedge clk) begin
    if (cfg_cen) begin
      bits.push_back(cfg_shift);
      if (cen_first < 0) cen_first = cyc;
    end
    if (!cfg_cen && cfg_shift) bad_shift++;
    if (cfg_set) begin n_set++; set_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (rb_valid) rb_q.push_back(rb_data);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    bits.delete();
    rb_q.delete();
    n_set = 0; n_done = 0; set_cyc = -1; done_cyc = -1; cen_first = -1; bad_shift = 0;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    clear_rec();
    start = 1'b1;
    cfg_len = len;
    @(negedge clk);
    start = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok = 1'b0;
    word_valid = 1'b1;
    word_data = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = word_ready;
      @(negedge clk);
    end
    word_valid = 1'b0;
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300 && n_done == 0; n++) @(negedge clk);
    chk("done_timeout", n_done > 0, 1);
    @(negedge clk);
  endtask

  function automatic logic [63:0] packed_bits();
    logic [63:0] v = '0;
    for (int i = 0; i < bits.size() && i < 64; i++) v[i] = bits[i];
    return v;
  endfunction

  initial begin
    int viol;
    clear_rec();
    repeat (3) @(negedge clk);
    chk("reset_outs", {word_ready, cfg_shift, cfg_cen, cfg_set, busy, done, rb_valid, rb_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 64-bit load over a chain preloaded with a known old image
    do_start(64);
    chk("busy_after_start", busy, 1);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    wait_done();
    chk("rb_len64_bits", bits.size(), 64);
    chk("chain_new_image", chain, 64'h2222_2222_1111_1111);
    chk("busy_after_done", busy, 0);
`ifdef CFG_READBACK_EN
    chk("rb_count", rb_q.size(), 2);
    if (rb_q.size() == 2) begin
      chk("rb_word0", rb_q[0], 32'h0123_4567);
      chk("rb_word1", rb_q[1], 32'hDEAD_BEEF);
    end
`else
    chk("rb_count_off", rb_q.size(), 0);
    chk("rb_data_off", rb_data, 0);
`endif

    // single full word and exact timing
    do_start(32);
    send_word(32'hA5A5_0F0F);
    wait_done();
    chk("full_bits", bits.size(), 32);
    chk("full_data", packed_bits(), 64'hA5A5_0F0F);
    chk("full_first_cen", cen_first - st_cyc, 1);
    chk("full_set_cyc", set_cyc - st_cyc, 33);
    chk("full_done_cyc", done_cyc - st_cyc, 34);
    chk("full_n_set", n_set, 1);

    // partial last word: upper bits of the second word must never shift
    do_start(40);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_01AB);
    wait_done();
    chk("part_bits", bits.size(), 40);
    chk("part_data", packed_bits(), 64'hAB_FFFF_FFFF);
    chk("part_set_cyc", set_cyc - st_cyc, 42);

    // producer stall between words
    do_start(64);
    send_word(32'h1234_5678);
    for (int n = 0; n < 100 && !word_ready; n++) @(negedge clk);
    viol = 0;
    repeat (10) begin
      if (cfg_cen || !word_ready) viol++;
      @(negedge clk);
    end
    chk("stall_quiet", viol, 0);
    send_word(32'h9ABC_DEF0);
    wait_done();
    chk("stall_bits", bits.size(), 64);
    chk("stall_data", packed_bits(), 64'h9ABC_DEF0_1234_5678);

    // zero length: set then done, no shifting
    do_start(0);
    repeat (3) @(negedge clk);
    chk("zero_set_cyc", set_cyc - st_cyc, 0);
    chk("zero_done_cyc", done_cyc - st_cyc, 1);
    chk("zero_no_cen", bits.size(), 0);
    chk("zero_n_set", n_set, 1);

    // start while busy is ignored
    do_start(32);
    send_word(32'hC3C3_5A5A);
    repeat (5) @(negedge clk);
    start = 1'b1;
    cfg_len = 8;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("ign_bits", bits.size(), 32);
    chk("ign_data", packed_bits(), 64'hC3C3_5A5A);
    chk("ign_n_done", n_done, 1);

    // reset mid-shift clears everything next cycle
    do_start(32);
    send_word(32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {word_ready, cfg_shift, cfg_cen, cfg_set, busy, done, rb_valid, rb_data}, 0);
    chk("midrst_no_set", n_set, 0);
    rst = 1'b0;
    @(negedge clk);

    // fresh load after the abort
    do_start(16);
    send_word(32'hFFFF_BEEF);
    wait_done();
    chk("fresh_bits", bits.size(), 16);
    chk("fresh_data", packed_bits(), 64'hBEEF);
    chk("fresh_n_set", n_set, 1);
    chk("shift_gated", bad_shift, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
